// File: rtl/btn_pkg.sv
// Shared types and constants for push-button conditioning.
// Pure definitions: no logic, no latency, no flow control.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARM_HI = 2'b01,
        HIGH   = 2'b10,
        ARM_LO = 2'b11
    } btn_state_t;

    localparam int CLK_HZ        = 100_000_000;
    localparam int DEBOUNCE_10MS = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pad bit, reset to 0.
// Latency 2 clk edges; no backpressure (free-running sampler).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw button into a registered level plus press/release pulses.
// Latency 2 + DEBOUNCE_CYCLES edges per accepted change; no backpressure.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s2;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // Counter restarts on every state change, so it can never pass TERM.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = ARM_HI;
                    cnt_nxt   = '0;
                end
            end
            ARM_HI: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == TERM) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nxt = ARM_LO;
                    cnt_nxt   = '0;
                end
            end
            ARM_LO: begin
                if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == TERM) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised scoreboard bench for btn_debounce using a run-length reference model.
module tb_btn_debounce;

    localparam int D = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic button = 1'b1;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    typedef struct {
        int edge_no;
        bit is_press;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    // Reference model: raw samples differing from the accepted level form a run;
    // a run of D+1 samples flips the level, visible 2 edges later (synchroniser).
    bit  m_level = 1'b0;
    int  m_run   = 0;
    bit  mon_level = 1'b0;

    btn_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Called at a negedge: drive the value sampled at the next posedge.
    task automatic step(input bit b);
        ev_t ev;
        button = b;
        if (b != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level    = b;
                m_run      = 0;
                ev.edge_no = cyc + 1 + 2;
                ev.is_press = b;
                exp_q.push_back(ev);
            end
        end else begin
            m_run = 0;
        end
        @(negedge clk);
    endtask

    task automatic hold(input bit b, input int n);
        repeat (n) step(b);
    endtask

    // Asserts reset between edges and checks outputs fall without a clock.
    task automatic do_reset(input bit b, input int n);
        #2;
        rst_n   = 1'b0;
        button  = b;
        m_level = 1'b0;
        m_run   = 0;
        exp_q.delete();
        #1;
        check("async_rst_level",   btn_level,   0);
        check("async_rst_press",   btn_press,   0);
        check("async_rst_release", btn_release, 0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_level = 1'b0;
                continue;
            end
            if (btn_press || btn_release) begin
                check("pulse_exclusive", int'(btn_press && btn_release), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(btn_press) + int'(btn_release), 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_edge", cyc, ev.edge_no);
                    check("pulse_type_press", btn_press, ev.is_press);
                    mon_level = ev.is_press;
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
                ev = exp_q.pop_front();
                check("missing_pulse", int'(btn_press || btn_release), 1);
                mon_level = ev.is_press;
            end
            check("level", btn_level, mon_level);
        end
    end

    initial begin
        // Held through reset: outputs stay low, then a full-latency fresh press.
        repeat (3) @(negedge clk);
        check("reset_level",   btn_level,   0);
        check("reset_press",   btn_press,   0);
        check("reset_release", btn_release, 0);
        rst_n = 1'b1;
        hold(1'b1, 12);

        // Clean release and press.
        hold(1'b0, 12);
        hold(1'b1, 20);
        hold(1'b0, 20);

        // Bounce: 3 high / 1 low five times, then settle high.
        repeat (5) begin
            hold(1'b1, 3);
            hold(1'b0, 1);
        end
        hold(1'b1, 12);

        // Short low glitch while high must not release.
        hold(1'b0, 2);
        hold(1'b1, 12);
        hold(1'b0, 12);

        // Stable-width boundary: one sample short, then exactly enough.
        hold(1'b1, D);
        hold(1'b0, 6);
        hold(1'b1, D + 1);
        hold(1'b0, D);
        hold(1'b1, 6);
        hold(1'b0, D + 1);
        hold(1'b1, 6);
        hold(1'b0, 12);

        // Reset while arming, button held high across deassertion.
        hold(1'b1, 3);
        do_reset(1'b1, 3);
        hold(1'b1, 10);
        // Reset while high: level drops at once, no release pulse.
        do_reset(1'b0, 2);
        hold(1'b0, 10);

        for (int i = 0; i < 150; i++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * D + 2));
        end
        hold(1'b0, 12);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
